// File: rtl/lsq_ring.sv
// Circular load-store queue: in-order allocation, oldest-eligible issue with
// store-to-load forwarding, in-order retirement from head, and full flush.
module lsq_ring #(
    parameter  int DEPTH  = 16,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int RET_W  = 2,
    localparam int TAG_W  = $clog2(DEPTH),
    localparam int RC_W   = $clog2(RET_W + 1)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              flush_i,
    input  logic              dis_valid_i,
    output logic              dis_ready_o,
    input  logic [ADDR_W-1:0] dis_pc_i,
    input  logic              dis_is_store_i,
    input  logic              dis_size_i,
    input  logic [DATA_W-1:0] dis_data_i,
    output logic [TAG_W-1:0]  dis_tag_o,
    input  logic              agu_valid_i,
    input  logic [TAG_W-1:0]  agu_tag_i,
    input  logic [ADDR_W-1:0] agu_addr_i,
    output logic              iss_valid_o,
    input  logic              iss_ready_i,
    output logic [TAG_W-1:0]  iss_tag_o,
    output logic [ADDR_W-1:0] iss_pc_o,
    output logic [ADDR_W-1:0] iss_addr_o,
    output logic              iss_is_store_o,
    output logic              iss_size_o,
    output logic [DATA_W-1:0] iss_data_o,
    output logic              fwd_valid_o,
    output logic [TAG_W-1:0]  fwd_tag_o,
    output logic [DATA_W-1:0] fwd_data_o,
    input  logic [RC_W-1:0]   ret_cnt_i,
    output logic [TAG_W:0]    count_o,
    output logic              empty_o
);
    localparam int CW = TAG_W + 1;

    logic [DEPTH-1:0]  valid_q, valid_d, store_q, store_d, size_q, size_d;
    logic [DEPTH-1:0]  known_q, known_d, done_q, done_d;
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] pc_d   [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic              lock_q, lock_d, lkStore_q, lkStore_d, lkSize_q, lkSize_d;
    logic [TAG_W-1:0]  lkTag_q, lkTag_d;
    logic [ADDR_W-1:0] lkPc_q, lkPc_d, lkAddr_q, lkAddr_d;
    logic [DATA_W-1:0] lkData_q, lkData_d;

    logic              pickFound, pickFwd, blocked, matchFound, disFire, full;
    logic [TAG_W-1:0]  pickIdx, idx, jdx, matchIdx;
    logic [DATA_W-1:0] fwdWord, fwdShift;
    logic [CW-1:0]     retN;

    assign full = (count_q == CW'(DEPTH));

    // Walk entries oldest-first; a load scans its older entries for an unknown
    // store address (blocks) and the youngest same-word store (forward source).
    always_comb begin
        pickFound  = 1'b0;
        pickFwd    = 1'b0;
        pickIdx    = '0;
        fwdWord    = '0;
        idx        = '0;
        jdx        = '0;
        blocked    = 1'b0;
        matchFound = 1'b0;
        matchIdx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx        = head_q + TAG_W'(k);
            blocked    = 1'b0;
            matchFound = 1'b0;
            matchIdx   = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (j < k) begin
                    jdx = head_q + TAG_W'(j);
                    if (valid_q[jdx] && store_q[jdx]) begin
                        if (!known_q[jdx]) begin
                            blocked = 1'b1;
                        end else if (addr_q[jdx][ADDR_W-1:2] == addr_q[idx][ADDR_W-1:2]) begin
                            matchFound = 1'b1;
                            matchIdx   = jdx;
                        end
                    end
                end
            end
            if (!pickFound && valid_q[idx] && known_q[idx] && !done_q[idx]) begin
                if (store_q[idx]) begin
                    pickFound = 1'b1;
                    pickIdx   = idx;
                end else if (!blocked) begin
                    if (matchFound && !size_q[matchIdx]) begin
                        pickFound = 1'b1;
                        pickFwd   = 1'b1;
                        pickIdx   = idx;
                        fwdWord   = data_q[matchIdx];
                    end else if (!(matchFound && !done_q[matchIdx])) begin
                        pickFound = 1'b1;
                        pickIdx   = idx;
                    end
                end
            end
        end
    end

    assign fwdShift       = fwdWord >> {addr_q[pickIdx][1:0], 3'b000};
    assign fwd_valid_o    = !lock_q && pickFound && pickFwd;
    assign fwd_tag_o      = pickIdx;
    assign fwd_data_o     = !fwd_valid_o ? '0 :
                            (size_q[pickIdx] ? {{(DATA_W-8){1'b0}}, fwdShift[7:0]} : fwdWord);

    // A stalled request keeps its captured fields so later AGU writes or
    // older entries becoming eligible cannot disturb it.
    assign iss_valid_o    = lock_q || (pickFound && !pickFwd);
    assign iss_tag_o      = lock_q ? lkTag_q   : pickIdx;
    assign iss_pc_o       = lock_q ? lkPc_q    : pc_q[pickIdx];
    assign iss_addr_o     = lock_q ? lkAddr_q  : addr_q[pickIdx];
    assign iss_is_store_o = lock_q ? lkStore_q : store_q[pickIdx];
    assign iss_size_o     = lock_q ? lkSize_q  : size_q[pickIdx];
    assign iss_data_o     = lock_q ? lkData_q  : data_q[pickIdx];

    assign dis_ready_o    = !full;
    assign dis_tag_o      = tail_q;
    assign count_o        = count_q;
    assign empty_o        = (count_q == '0);

    always_comb begin
        valid_d   = valid_q;
        store_d   = store_q;
        size_d    = size_q;
        known_d   = known_q;
        done_d    = done_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        data_d    = data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        lock_d    = lock_q;
        lkTag_d   = lkTag_q;
        lkPc_d    = lkPc_q;
        lkAddr_d  = lkAddr_q;
        lkStore_d = lkStore_q;
        lkSize_d  = lkSize_q;
        lkData_d  = lkData_q;
        disFire   = dis_valid_i && !full;
        retN      = (CW'(ret_cnt_i) > count_q) ? count_q : CW'(ret_cnt_i);

        if (disFire) begin
            valid_d[tail_q] = 1'b1;
            store_d[tail_q] = dis_is_store_i;
            size_d[tail_q]  = dis_size_i;
            known_d[tail_q] = 1'b0;
            done_d[tail_q]  = 1'b0;
            pc_d[tail_q]    = dis_pc_i;
            data_d[tail_q]  = dis_data_i;
            tail_d          = tail_q + 1'b1;
        end
        if (agu_valid_i && valid_q[agu_tag_i]) begin
            addr_d[agu_tag_i]  = agu_addr_i;
            known_d[agu_tag_i] = 1'b1;
        end
        if (iss_valid_o && iss_ready_i) begin
            done_d[iss_tag_o] = 1'b1;
            lock_d            = 1'b0;
        end else if (iss_valid_o && !lock_q) begin
            lock_d    = 1'b1;
            lkTag_d   = iss_tag_o;
            lkPc_d    = iss_pc_o;
            lkAddr_d  = iss_addr_o;
            lkStore_d = iss_is_store_o;
            lkSize_d  = iss_size_o;
            lkData_d  = iss_data_o;
        end
        if (fwd_valid_o) begin
            done_d[pickIdx] = 1'b1;
        end
        for (int r = 0; r < RET_W; r++) begin
            if (CW'(r) < retN) begin
                valid_d[head_q + TAG_W'(r)] = 1'b0;
            end
        end
        head_d  = head_q + TAG_W'(retN);
        count_d = count_q + CW'(disFire) - retN;

        if (flush_i) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            lock_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q   <= '0;
            store_q   <= '0;
            size_q    <= '0;
            known_q   <= '0;
            done_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            lock_q    <= 1'b0;
            lkTag_q   <= '0;
            lkPc_q    <= '0;
            lkAddr_q  <= '0;
            lkStore_q <= 1'b0;
            lkSize_q  <= 1'b0;
            lkData_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            store_q   <= store_d;
            size_q    <= size_d;
            known_q   <= known_d;
            done_q    <= done_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            lock_q    <= lock_d;
            lkTag_q   <= lkTag_d;
            lkPc_q    <= lkPc_d;
            lkAddr_q  <= lkAddr_d;
            lkStore_q <= lkStore_d;
            lkSize_q  <= lkSize_d;
            lkData_q  <= lkData_d;
        end
    end
endmodule

// File: tb/tb_lsq_ring.sv
// Directed bench for lsq_ring: a per-cycle vector table for the forwarding and
// ordering cases, then hand sequences for full/wrap, stalled issue, flush and reset.
module tb_lsq_ring;
    logic        clk = 1'b0;
    logic        rstn, flush, disValid, disReady, disStore, disSize;
    logic [31:0] disPc, disData;
    logic [3:0]  disTag;
    logic        aguValid;
    logic [3:0]  aguTag;
    logic [31:0] aguAddr;
    logic        issValid, issReady, issStore, issSize;
    logic [3:0]  issTag;
    logic [31:0] issPc, issAddr, issData;
    logic        fwdValid;
    logic [3:0]  fwdTag;
    logic [31:0] fwdData;
    logic [1:0]  retCnt;
    logic [4:0]  count;
    logic        empty;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic        flush, disValid, disStore, disSize;
        logic [31:0] disData;
        logic        aguValid;
        logic [3:0]  aguTag;
        logic [31:0] aguAddr;
        logic        issReady;
        logic [1:0]  retCnt;
        logic [4:0]  expCount;
        logic [3:0]  expDisTag;
        logic        expDisReady, expIssValid;
        logic [3:0]  expIssTag;
        logic [31:0] expIssAddr;
        logic        expIssStore;
        logic [31:0] expIssData;
        logic        expFwdValid;
        logic [3:0]  expFwdTag;
        logic [31:0] expFwdData;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    lsq_ring dut (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
        .dis_valid_i(disValid), .dis_ready_o(disReady), .dis_pc_i(disPc),
        .dis_is_store_i(disStore), .dis_size_i(disSize), .dis_data_i(disData),
        .dis_tag_o(disTag),
        .agu_valid_i(aguValid), .agu_tag_i(aguTag), .agu_addr_i(aguAddr),
        .iss_valid_o(issValid), .iss_ready_i(issReady), .iss_tag_o(issTag),
        .iss_pc_o(issPc), .iss_addr_o(issAddr), .iss_is_store_o(issStore),
        .iss_size_o(issSize), .iss_data_o(issData),
        .fwd_valid_o(fwdValid), .fwd_tag_o(fwdTag), .fwd_data_o(fwdData),
        .ret_cnt_i(retCnt), .count_o(count), .empty_o(empty)
    );

    // Retiring an entry that never issued or forwarded is a caller error.
    logic       doneM [16];
    logic [3:0] headM;
    int         retN;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            headM <= 4'd0;
            for (int i = 0; i < 16; i++) doneM[i] <= 1'b0;
        end else if (flush) begin
            headM <= 4'd0;
            for (int i = 0; i < 16; i++) doneM[i] <= 1'b0;
        end else begin
            retN = (int'(retCnt) > int'(count)) ? int'(count) : int'(retCnt);
            for (int r = 0; r < retN; r++)
                assert (doneM[4'(int'(headM) + r)])
                    else $error("[TB] caller error: retiring tag %0d before it completed", 4'(int'(headM) + r));
            headM <= headM + 4'(retN);
            if (issValid && issReady) doneM[issTag] <= 1'b1;
            if (fwdValid) doneM[fwdTag] <= 1'b1;
            if (disValid && disReady) doneM[disTag] <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: bench did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        flush = 1'b0; disValid = 1'b0; disStore = 1'b0; disSize = 1'b0;
        disPc = 32'h0; disData = 32'h0; aguValid = 1'b0; aguTag = 4'd0;
        aguAddr = 32'h0; issReady = 1'b0; retCnt = 2'd0;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input int fl, dv, ds, dz, dd, av, at, aa, rdy, rc,
                                input int ec, et, er, iv, it, ia, ist, id, fv, ft, fd);
        vec_t v;
        v.flush = fl[0]; v.disValid = dv[0]; v.disStore = ds[0]; v.disSize = dz[0];
        v.disData = 32'(dd); v.aguValid = av[0]; v.aguTag = 4'(at); v.aguAddr = 32'(aa);
        v.issReady = rdy[0]; v.retCnt = 2'(rc);
        v.expCount = 5'(ec); v.expDisTag = 4'(et); v.expDisReady = er[0];
        v.expIssValid = iv[0]; v.expIssTag = 4'(it); v.expIssAddr = 32'(ia);
        v.expIssStore = ist[0]; v.expIssData = 32'(id);
        v.expFwdValid = fv[0]; v.expFwdTag = 4'(ft); v.expFwdData = 32'(fd);
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v, input int n);
        flush = v.flush; disValid = v.disValid; disStore = v.disStore; disSize = v.disSize;
        disData = v.disData; disPc = 32'h1000 + 32'(n * 4);
        aguValid = v.aguValid; aguTag = v.aguTag; aguAddr = v.aguAddr;
        issReady = v.issReady; retCnt = v.retCnt;
    endtask

    task automatic checkVec(input vec_t v, input int n);
        checkOutput($sformatf("v%0d count", n), 32'(count), 32'(v.expCount));
        checkOutput($sformatf("v%0d dis_tag", n), 32'(disTag), 32'(v.expDisTag));
        checkOutput($sformatf("v%0d dis_ready", n), 32'(disReady), 32'(v.expDisReady));
        checkOutput($sformatf("v%0d iss_valid", n), 32'(issValid), 32'(v.expIssValid));
        checkOutput($sformatf("v%0d fwd_valid", n), 32'(fwdValid), 32'(v.expFwdValid));
        if (v.expIssValid) begin
            checkOutput($sformatf("v%0d iss_tag", n), 32'(issTag), 32'(v.expIssTag));
            checkOutput($sformatf("v%0d iss_addr", n), issAddr, v.expIssAddr);
            checkOutput($sformatf("v%0d iss_is_store", n), 32'(issStore), 32'(v.expIssStore));
            if (v.expIssStore)
                checkOutput($sformatf("v%0d iss_data", n), issData, v.expIssData);
        end
        if (v.expFwdValid) begin
            checkOutput($sformatf("v%0d fwd_tag", n), 32'(fwdTag), 32'(v.expFwdTag));
            checkOutput($sformatf("v%0d fwd_data", n), fwdData, v.expFwdData);
        end
    endtask

    initial begin
        idleInputs();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // fl dv ds dz data          av tag addr    rdy rc | cnt tag rdy iv itag iaddr  ist idata         fv ftag fdata
        vecs.push_back(mk(0,1,1,0,32'hDEADBEEF, 0,0,0,      0,0,  0,0,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,1,0,0,0,            0,0,0,      0,0,  1,1,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            1,0,32'h100,0,0,  2,2,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            1,1,32'h100,1,0,  2,2,1, 1,0,32'h100,1,32'hDEADBEEF, 0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,      0,0,  2,2,1, 0,0,0,      0,0,            1,1,32'hDEADBEEF));
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,      0,2,  2,2,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,1,1,0,32'h11223344, 0,0,0,      0,0,  0,2,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,1,0,1,0,            0,0,0,      0,0,  1,3,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            1,3,32'h202,0,0,  2,4,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            1,2,32'h200,0,0,  2,4,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,      1,0,  2,4,1, 1,2,32'h200,1,32'h11223344, 0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,      0,0,  2,4,1, 0,0,0,      0,0,            1,3,32'h22));
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,      0,2,  2,4,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,1,1,0,32'hCAFE0000, 0,0,0,      0,0,  0,4,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,1,0,0,0,            0,0,0,      0,0,  1,5,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            1,5,32'h304,0,0,  2,6,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            1,4,32'h300,1,0,  2,6,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,      1,0,  2,6,1, 1,4,32'h300,1,32'hCAFE0000, 0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,      1,0,  2,6,1, 1,5,32'h304,0,0,            0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,      0,2,  2,6,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,1,1,1,32'h000000AB, 0,0,0,      0,0,  0,6,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,1,0,0,0,            0,0,0,      0,0,  1,7,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            1,6,32'h400,0,0,  2,8,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            1,7,32'h400,0,0,  2,8,1, 1,6,32'h400,1,32'hAB,       0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,      0,0,  2,8,1, 1,6,32'h400,1,32'hAB,       0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,      1,0,  2,8,1, 1,6,32'h400,1,32'hAB,       0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,      1,0,  2,8,1, 1,7,32'h400,0,0,            0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,      0,2,  2,8,1, 0,0,0,      0,0,            0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,      0,0,  0,8,1, 0,0,0,      0,0,            0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
            #1;
            checkVec(vecs[i], i);
            cycle();
        end

        // Younger load stalls on iss while the older one gains its address.
        idleInputs(); disValid = 1'b1; disPc = 32'h2000; cycle();
        disPc = 32'h2004; cycle();
        idleInputs(); aguValid = 1'b1; aguTag = 4'd9; aguAddr = 32'h500; cycle();
        aguTag = 4'd8; aguAddr = 32'h600;
        #1;
        checkOutput("t5 first iss_valid", 32'(issValid), 32'd1);
        checkOutput("t5 first iss_tag", 32'(issTag), 32'd9);
        cycle();
        for (int i = 0; i < 4; i++) begin
            idleInputs();
            if (i == 1) begin
                aguValid = 1'b1; aguTag = 4'd9; aguAddr = 32'h700;
            end
            #1;
            checkOutput($sformatf("t5 hold%0d iss_valid", i), 32'(issValid), 32'd1);
            checkOutput($sformatf("t5 hold%0d iss_tag", i), 32'(issTag), 32'd9);
            checkOutput($sformatf("t5 hold%0d iss_addr", i), issAddr, 32'h500);
            checkOutput($sformatf("t5 hold%0d iss_pc", i), issPc, 32'h2004);
            checkOutput($sformatf("t5 hold%0d fwd_valid", i), 32'(fwdValid), 32'd0);
            cycle();
        end
        idleInputs(); issReady = 1'b1;
        #1;
        checkOutput("t5 accept iss_tag", 32'(issTag), 32'd9);
        checkOutput("t5 accept iss_addr", issAddr, 32'h500);
        cycle();
        #1;
        checkOutput("t5 older iss_valid", 32'(issValid), 32'd1);
        checkOutput("t5 older iss_tag", 32'(issTag), 32'd8);
        checkOutput("t5 older iss_addr", issAddr, 32'h600);
        checkOutput("t5 older iss_pc", issPc, 32'h2000);
        cycle();
        idleInputs(); retCnt = 2'd2;
        #1;
        checkOutput("t5 drained iss_valid", 32'(issValid), 32'd0);
        cycle();
        idleInputs();
        #1;
        checkOutput("t5 final count", 32'(count), 32'd0);
        checkOutput("t5 final dis_tag", 32'(disTag), 32'd10);

        // Reset values, then fill to full and wrap the tail.
        rstn = 1'b0;
        #1;
        checkOutput("rst count", 32'(count), 32'd0);
        checkOutput("rst dis_tag", 32'(disTag), 32'd0);
        checkOutput("rst dis_ready", 32'(disReady), 32'd1);
        checkOutput("rst iss_valid", 32'(issValid), 32'd0);
        checkOutput("rst fwd_valid", 32'(fwdValid), 32'd0);
        checkOutput("rst empty", 32'(empty), 32'd1);
        cycle();
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            idleInputs(); disValid = 1'b1; disPc = 32'h3000 + 32'(i * 4);
            #1;
            checkOutput($sformatf("t1 fill%0d dis_tag", i), 32'(disTag), 32'(i));
            checkOutput($sformatf("t1 fill%0d dis_ready", i), 32'(disReady), 32'd1);
            cycle();
        end
        idleInputs(); disValid = 1'b1;
        #1;
        checkOutput("t1 full count", 32'(count), 32'd16);
        checkOutput("t1 full dis_ready", 32'(disReady), 32'd0);
        checkOutput("t1 full dis_tag", 32'(disTag), 32'd0);
        checkOutput("t1 full empty", 32'(empty), 32'd0);
        cycle();
        idleInputs(); aguValid = 1'b1; aguTag = 4'd0; aguAddr = 32'h800;
        #1;
        checkOutput("t1 overfill count", 32'(count), 32'd16);
        cycle();
        idleInputs(); aguValid = 1'b1; aguTag = 4'd1; aguAddr = 32'h804; issReady = 1'b1;
        #1;
        checkOutput("t1 iss0 tag", 32'(issTag), 32'd0);
        cycle();
        idleInputs(); issReady = 1'b1;
        #1;
        checkOutput("t1 iss1 tag", 32'(issTag), 32'd1);
        checkOutput("t1 iss1 addr", issAddr, 32'h804);
        cycle();
        idleInputs(); retCnt = 2'd2; disValid = 1'b1;
        #1;
        checkOutput("t1 retiring dis_ready", 32'(disReady), 32'd0);
        cycle();
        idleInputs(); disValid = 1'b1;
        #1;
        checkOutput("t1 after retire count", 32'(count), 32'd14);
        checkOutput("t1 after retire dis_ready", 32'(disReady), 32'd1);
        checkOutput("t1 after retire dis_tag", 32'(disTag), 32'd0);
        cycle();
        idleInputs();
        #1;
        checkOutput("t1 wrapped count", 32'(count), 32'd15);
        checkOutput("t1 wrapped dis_tag", 32'(disTag), 32'd1);

        // Flush with seven entries and a stalled request, competing inputs asserted.
        flush = 1'b1; cycle();
        idleInputs();
        #1;
        checkOutput("t6 clean count", 32'(count), 32'd0);
        checkOutput("t6 clean dis_tag", 32'(disTag), 32'd0);
        for (int i = 0; i < 7; i++) begin
            idleInputs(); disValid = 1'b1; disPc = 32'h4000 + 32'(i * 4);
            cycle();
        end
        idleInputs(); aguValid = 1'b1; aguTag = 4'd3; aguAddr = 32'h900; cycle();
        idleInputs();
        #1;
        checkOutput("t6 pre-lock iss_tag", 32'(issTag), 32'd3);
        cycle();
        flush = 1'b1; disValid = 1'b1; aguValid = 1'b1; aguTag = 4'd4; aguAddr = 32'h904;
        issReady = 1'b1; retCnt = 2'd2;
        #1;
        checkOutput("t6 locked iss_valid", 32'(issValid), 32'd1);
        checkOutput("t6 locked count", 32'(count), 32'd7);
        cycle();
        idleInputs();
        #1;
        checkOutput("t6 flush count", 32'(count), 32'd0);
        checkOutput("t6 flush iss_valid", 32'(issValid), 32'd0);
        checkOutput("t6 flush dis_tag", 32'(disTag), 32'd0);
        checkOutput("t6 flush empty", 32'(empty), 32'd1);
        checkOutput("t6 flush fwd_valid", 32'(fwdValid), 32'd0);

        // Asynchronous reset while a request is stalled on the iss channel.
        idleInputs(); disValid = 1'b1; cycle();
        cycle();
        idleInputs(); aguValid = 1'b1; aguTag = 4'd0; aguAddr = 32'hA00; cycle();
        idleInputs(); cycle();
        #1;
        checkOutput("t6 stalled iss_valid", 32'(issValid), 32'd1);
        checkOutput("t6 stalled iss_addr", issAddr, 32'hA00);
        #2 rstn = 1'b0;
        #1;
        checkOutput("t6 async iss_valid", 32'(issValid), 32'd0);
        checkOutput("t6 async count", 32'(count), 32'd0);
        checkOutput("t6 async dis_tag", 32'(disTag), 32'd0);
        checkOutput("t6 async dis_ready", 32'(disReady), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        cycle();
        #1;
        checkOutput("t6 post-reset iss_valid", 32'(issValid), 32'd0);
        checkOutput("t6 post-reset count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
